// File: rtl/pipe_stage_pkg.sv
// Shared types for the pipe_stage register slice: state encoding and occupancy width.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    function automatic logic [OCC_W-1:0] occ_of_state(input state_e s);
        logic [OCC_W-1:0] occ;
        occ = '0;
        case (s)
            EMPTY:   occ = 2'd0;
            FULL:    occ = 2'd1;
            SKID:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready payload channel; master drives valid/data, slave drives ready.
interface pipe_stage_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_entry.sv
// One payload register of the slice: load, synchronous clear, asynchronous reset to zero.
module pipe_stage_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Clear wins over load so a squash never lets a same-cycle payload in.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage.sv
// Decode->execute register slice with flush. Define PIPE_STAGE_SKID_EN for the
// two-entry skid version with a registered in_ready; otherwise a single entry.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               flush_i,
    pipe_stage_if.slave        in_if,
    pipe_stage_if.master       out_if,
    output logic [OCC_W-1:0]   occupancy_o
);

    // state | meaning
    // EMPTY | nothing held, out_valid low
    // FULL  | main entry holds the head payload
    // SKID  | main + skid both held, upstream stalled

    state_e           state_q;
    state_e           state_d;
    logic             in_ready;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;
    logic             main_load;
    logic             entry_clear;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_load;
    logic             main_from_skid;
    logic             in_ready_q;
    logic [WIDTH-1:0] skid_q;
`endif

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_if.valid & in_ready;
    assign out_fire  = out_valid & out_if.ready;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
`endif
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = FULL;
                    main_load = 1'b1;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                end else if (in_fire) begin
                    state_d   = SKID;
                    skid_load = 1'b1;
`endif
                end
            end
            SKID: begin
`ifdef PIPE_STAGE_SKID_EN
                if (out_fire) begin
                    state_d        = FULL;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
`else
                state_d = EMPTY;
`endif
            end
            default: state_d = EMPTY;
        endcase

        // Flush overrides every transition and discards same-cycle transfers.
        if (flush_i) begin
            state_d   = EMPTY;
            main_load = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            skid_load      = 1'b0;
            main_from_skid = 1'b0;
`endif
        end
    end

    assign entry_clear = flush_i & CLEAR_ON_FLUSH;

`ifdef PIPE_STAGE_SKID_EN
    assign main_d = main_from_skid ? skid_q : in_if.data;

    pipe_stage_entry #(.WIDTH(WIDTH)) u_skid (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .load_i  (skid_load),
        .clear_i (entry_clear),
        .d_i     (in_if.data),
        .q_o     (skid_q)
    );

    // Registered ready breaks the out_ready -> in_ready path; reset value is 1.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != SKID);
        end
    end

    assign in_ready = in_ready_q;
`else
    assign main_d   = in_if.data;
    assign in_ready = !out_valid | out_if.ready;
`endif

    pipe_stage_entry #(.WIDTH(WIDTH)) u_main (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .load_i  (main_load),
        .clear_i (entry_clear),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;
    assign occupancy_o  = occ_of_state(state_q);

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, 32, payload width in bits (1..256).
REQ-002 Parameter CLEAR_ON_FLUSH, 1, when 1 payload registers load zero on flush; when 0 they hold.
REQ-003 Port clock  input  1  single clock; all state on rising edge.
REQ-004 Port reset  input  1  reset is asynchronous and active-high.
REQ-005 Port flush  input  1  synchronous squash of all held entries.
REQ-006 Port in_valid  input  1  upstream (decode-side) payload valid.
REQ-007 Port in_ready  output  1  stage accepts payload this cycle.
REQ-008 Port in_data  input  WIDTH  upstream payload.
REQ-009 Port out_valid  output  1  downstream (execute-side) payload valid.
REQ-010 Port out_ready  input  1  downstream accepts payload this cycle.
REQ-011 Port out_data  output  WIDTH  downstream payload.
REQ-012 Port occupancy  output  2  entries held, 0..2.

Function
REQ-013 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; transfers occur only on fire.
REQ-014 Latency in_fire to out_valid SHALL be exactly 1 cycle; sustained throughput 1 payload/cycle when out_ready stays high.
REQ-015 States: EMPTY (occupancy 0), FULL (main entry valid, occupancy 1), SKID (main+skid valid, occupancy 2, skid mode only).
REQ-016 EMPTY: in_fire -> FULL, main <= in_data; else stay.
REQ-017 FULL: out_fire & in_fire -> FULL, main <= in_data; out_fire only -> EMPTY; in_fire only -> SKID, skid <= in_data; neither -> hold.
REQ-018 SKID: in_ready = 0; out_fire -> FULL, main <= skid; else hold.
REQ-019 out_valid = (state != EMPTY); out_data = main entry.
REQ-020 While out_valid & !out_ready, out_valid and out_data SHALL remain stable.
REQ-021 Payloads leave in acceptance order; none dropped or duplicated except via flush.
REQ-022 flush has priority over all transitions: next state EMPTY, out_valid 0 next cycle, simultaneous in_fire/out_fire payloads discarded; payload registers zeroed iff CLEAR_ON_FLUSH = 1.
REQ-023 After reset or cleared flush, out_data SHALL read 0 until next load.

Reset
REQ-024 Asynchronous assertion of reset SHALL force state EMPTY, out_valid 0, occupancy 0, main and skid 0, regardless of clock.
REQ-025 in_ready SHALL be 1 while reset asserted in skid mode and 1 (from !out_valid) in non-skid mode; first in_fire possible on first rising edge after deassertion.
REQ-026 Reset asserted mid-transfer SHALL discard all held payloads.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN defined: skid entry present; in_ready = (state != SKID), driven from a register, no combinational path out_ready -> in_ready.
REQ-028 PIPE_STAGE_SKID_EN undefined: no skid entry, state SKID unreachable; in_ready = !out_valid | out_ready (combinational); occupancy max 1; FULL with in_fire & out_fire reloads main.

Structure
REQ-029 Package pipe_pkg SHALL hold the state enum typedef (EMPTY, FULL, SKID) and OCC_W = 2.
REQ-030 Sub-module pipe_stage_entry (WIDTH-bit register with load, clear, async reset) SHALL implement main and skid entries.

Verification
REQ-031 Reset release, in_valid=1 in_data=0xA5A5_0001, out_ready=1 -> out_valid=1 out_data=0xA5A5_0001 next cycle, occupancy 1.
REQ-032 Stream 0x1..0x8 back-to-back, out_ready=1 -> 0x1..0x8 out on consecutive cycles, in_ready never low.
REQ-033 Skid: load 0x10, out_ready=0, send 0x11 -> occupancy 2, in_ready 0, out_data 0x10 stable; raise out_ready -> 0x10 then 0x11 exit, in_ready 1 one cycle after first out_fire.
REQ-034 Flush in SKID with in_valid=1 0x22 -> next cycle occupancy 0, out_valid 0, out_data 0 (CLEAR_ON_FLUSH=1), 0x22 never appears.
REQ-035 Async reset asserted between edges while FULL with 0x33 -> out_valid 0 immediately, 0x33 never emitted.
REQ-036 Non-skid build: FULL, out_ready=0 -> in_ready 0 same cycle; out_ready=1 with in_valid 0x44 -> in_ready 1, 0x44 out next cycle.
